// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, register map and STATUS layout for the buffered UART
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

    localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_W   = 4;

    // Occupancy shown in STATUS clamps at 15 so deeper FIFOs still fit the 4-bit field
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        if (c > 32'd15) begin
            return 4'hF;
        end
        return c[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with extra-MSB pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A simultaneous pop frees the slot, so a push to a full FIFO still lands
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer advance; the extra MSB distinguishes full from empty across wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered memory-mapped UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN)
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int             BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int             BCW       = $clog2(BAUD_DIV);
    localparam int             FAW       = $clog2(FIFO_DEPTH);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);

    uart_tx_state_e r_state;
    logic [BCW-1:0] r_baud;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_tx;
    logic           r_ovf;
`ifdef UART_TX_PARITY_EN
    logic           r_parity;
`endif

    logic                  w_sel_status;
    logic                  w_sel_txdata;
    logic                  w_wr_txdata;
    logic                  w_wr_status;
    logic                  w_pop;
    logic                  w_baud_done;
    logic                  w_busy;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [7:0]            w_fifo_dout;
    logic [FAW:0]          w_fifo_count;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_unused;

    // Only address[2] selects the register; the other bits are don't-care
    assign w_sel_status = (address[2] == UART_STATUS_OFS[2]);
    assign w_sel_txdata = (address[2] == UART_TXDATA_OFS[2]);
    assign w_wr_txdata  = we && w_sel_txdata;
    assign w_wr_status  = we && w_sel_status;
    assign w_unused     = ^{address[DATA_WIDTH-1:3], address[1:0], wd[DATA_WIDTH-1:8]};

    // The FSM only pops from IDLE, which inserts the single idle cycle between frames
    assign w_pop       = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_busy      = (r_state != ST_IDLE) || !w_fifo_empty;

    assign tx      = r_tx;
    assign tx_busy = w_busy;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_wr_txdata),
        .pop   (w_pop),
        .din   (wd[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Sticky overflow: set when a byte is refused, cleared by software through STATUS bit 3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_wr_txdata && w_fifo_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && wd[STATUS_OVF_BIT]) begin
            r_ovf <= 1'b0;
        end
    end

    // Frame sequencer; tx is registered alongside the state so the line never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_shift <= w_fifo_dout;
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_fifo_dout;
`endif
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // STATUS image built from registered state, zero-extended to the bus width
    always_comb begin
        w_status                                        = '0;
        w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W]    = sat_count4(32'(w_fifo_count));
        w_status[STATUS_OVF_BIT]                        = r_ovf;
        w_status[STATUS_BUSY_BIT]                       = w_busy;
        w_status[STATUS_EMPTY_BIT]                      = w_fifo_empty;
        w_status[STATUS_FULL_BIT]                       = w_fifo_full;
    end

    // Read mux: TXDATA reads and deselected reads return zero
    always_comb begin
        rd = '0;
        if (re && w_sel_status) begin
            rd = w_status;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered
module tb_uart_tx_buffered;

    localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] address = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rd;
    logic        tx;
    logic        tx_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         start;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       stable;
    } frame_t;

    frame_t     got_q[$];
    logic [7:0] exp_q[$];

    uart_tx_buffered #(
        .DATA_WIDTH (32),
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wd      (wd),
        .address (address),
        .we      (we),
        .re      (re),
        .rd      (rd),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples tx on falling edges and records every complete frame
    initial begin : frame_monitor
        logic       active;
        int         n;
        int         start;
        logic [10:0] bits;
        logic       cur;
        logic       stable;
        frame_t     rec;
        active = 1'b0; n = 0; start = 0; bits = '0; cur = 1'b1; stable = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1; start = cyc; bits = '0; cur = 1'b0; stable = 1'b1; n = 1;
                end
            end else begin
                if (n % BD == 0) begin
                    cur = tx;
                    bits[n / BD] = tx;
                end else if (tx !== cur) begin
                    stable = 1'b0;
                end
                n++;
                if (n == FRAME) begin
                    rec.start = start; rec.data = bits[8:1]; rec.par = bits[9];
                    rec.stop = bits[NBITS-1]; rec.stable = stable;
                    got_q.push_back(rec);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; address = a; wd = d;
        @(negedge clk);
        we = 1'b0; address = '0; wd = '0;
    endtask

    task automatic read_status(output logic [31:0] v);
        re = 1'b1; address = 32'h4;
        #1;
        v = rd;
        re = 1'b0; address = '0;
    endtask

    task automatic wait_frames(input int n, input int max_cyc, output bit ok);
        int k = 0;
        while (got_q.size() < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        int k = 0;
        while (tx_busy !== 1'b0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        ok = (tx_busy === 1'b0);
    endtask

    task automatic test_reset;
        logic [31:0] s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_rd: got %h expected 0", rd); end
        rst_n = 1'b1;
        @(negedge clk);
        read_status(s);
        checks++; if (s !== 32'h2) begin failures++; $display("FAIL reset_status: got %h expected 2", s); end
    endtask

    task automatic test_single;
        logic [31:0] s;
        int c0, tb;
        bit ok;
        frame_t f;
        logic [7:0] e;
        @(negedge clk);
        c0 = cyc;
        we = 1'b1; address = 32'h0; wd = 32'hABCD_EF55;
        exp_q.push_back(8'h55);
        @(negedge clk);
        we = 1'b0; wd = '0;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_tx_before_start: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL single_busy_queued: got %b expected 1", tx_busy); end
        read_status(s);
        checks++; if (s !== 32'h14) begin failures++; $display("FAIL single_status: got %h expected 14", s); end
        wait_frames(1, FRAME + 20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL single_timeout: got %0d frames expected 1", got_q.size());
        end else begin
            f = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (f.start !== c0 + 2) begin failures++; $display("FAIL single_latency: got %0d expected %0d", f.start - c0, 2); end
            checks++; if (f.data !== e) begin failures++; $display("FAIL single_data: got %h expected %h", f.data, e); end
            checks++; if (f.stop !== 1'b1 || f.stable !== 1'b1) begin failures++; $display("FAIL single_shape: stop %b stable %b expected 1 1", f.stop, f.stable); end
            wait_idle(30, ok);
            tb = cyc;
            checks++; if (!ok || tb !== f.start + FRAME) begin failures++; $display("FAIL single_busy_fall: got %0d expected %0d", tb - f.start, FRAME); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] s;
        int c0;
        bit ok;
        frame_t f[3];
        logic [7:0] e;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; address = 32'h0; wd = 32'(8'h41 + i);
            exp_q.push_back(8'(8'h41 + i));
            @(negedge clk);
        end
        we = 1'b0; wd = '0;
        read_status(s);
        checks++; if (s !== 32'h24) begin failures++; $display("FAIL b2b_status_count: got %h expected 24", s); end
        wait_frames(3, 3 * (FRAME + 1) + 20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL b2b_timeout: got %0d frames expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                f[i] = got_q.pop_front(); e = exp_q.pop_front();
                checks++; if (f[i].data !== e || f[i].stable !== 1'b1) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, f[i].data, e); end
            end
            checks++; if (f[0].start !== c0 + 2) begin failures++; $display("FAIL b2b_latency: got %0d expected 2", f[0].start - c0); end
            for (int i = 1; i < 3; i++) begin
                checks++; if (f[i].start !== f[i-1].start + FRAME + 1) begin failures++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, f[i].start - f[i-1].start, FRAME + 1); end
            end
        end
        wait_idle(FRAME, ok);
    endtask

    task automatic test_overflow;
        logic [31:0] s;
        bit ok;
        frame_t f;
        logic [7:0] e;
        for (int round = 0; round < 2; round++) begin
            @(negedge clk);
            for (int i = 0; i < 9 + round; i++) begin
                we = 1'b1; address = 32'h0; wd = 32'(8'h10 + 8'(round * 8'h40) + 8'(i));
                if (i < 9) exp_q.push_back(8'(8'h10 + round * 8'h40 + i));
                @(negedge clk);
            end
            we = 1'b0; wd = '0;
            read_status(s);
            if (round == 0) begin
                checks++; if (s !== 32'h85) begin failures++; $display("FAIL ovf_nine_status: got %h expected 85", s); end
            end else begin
                checks++; if (s !== 32'h8D) begin failures++; $display("FAIL ovf_ten_status: got %h expected 8d", s); end
                do_write(32'h4, 32'h7);
                read_status(s);
                checks++; if (s !== 32'h8D) begin failures++; $display("FAIL ovf_keep_status: got %h expected 8d", s); end
                do_write(32'h4, 32'h8);
                read_status(s);
                checks++; if (s !== 32'h85) begin failures++; $display("FAIL ovf_clear_status: got %h expected 85", s); end
            end
            wait_frames(9, 9 * (FRAME + 1) + 40, ok);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL ovf_timeout: got %0d frames expected 9", got_q.size());
            end else begin
                for (int i = 0; i < 9; i++) begin
                    f = got_q.pop_front(); e = exp_q.pop_front();
                    checks++; if (f.data !== e || f.stop !== 1'b1) begin failures++; $display("FAIL ovf_data%0d: got %h expected %h", i, f.data, e); end
                end
            end
            wait_idle(FRAME + 20, ok);
            checks++; if (!ok || got_q.size() != 0) begin failures++; $display("FAIL ovf_extra_frames: got %0d expected 0", got_q.size()); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        bit ok;
        frame_t f0, f1;
        @(negedge clk);
        we = 1'b1; address = 32'h0; wd = 32'h07; exp_q.push_back(8'h07);
        @(negedge clk);
        wd = 32'h03; exp_q.push_back(8'h03);
        @(negedge clk);
        we = 1'b0; wd = '0;
        wait_frames(2, 2 * (FRAME + 1) + 20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL parity_timeout: got %0d frames expected 2", got_q.size());
        end else begin
            f0 = got_q.pop_front(); f1 = got_q.pop_front();
            checks++; if (f0.data !== exp_q.pop_front()) begin failures++; $display("FAIL parity_data0: got %h expected 07", f0.data); end
            checks++; if (f1.data !== exp_q.pop_front()) begin failures++; $display("FAIL parity_data1: got %h expected 03", f1.data); end
            checks++; if (f0.par !== 1'b1) begin failures++; $display("FAIL parity_bit07: got %b expected 1", f0.par); end
            checks++; if (f1.par !== 1'b0) begin failures++; $display("FAIL parity_bit03: got %b expected 0", f1.par); end
            checks++; if (f1.start - f0.start !== 111) begin failures++; $display("FAIL parity_frame_len: got %0d expected 111", f1.start - f0.start); end
        end
        wait_idle(FRAME, ok);
    endtask
`endif

    task automatic test_reset_mid_frame;
        logic [31:0] s;
        bit stayed_high;
        @(negedge clk);
        we = 1'b1; address = 32'h0; wd = 32'hA5;
        @(negedge clk);
        wd = 32'h5A;
        @(negedge clk);
        we = 1'b0; wd = '0;
        repeat (25) @(negedge clk);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL rst_mid_bit1: got %b expected 0", tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", tx_busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_status(s);
        checks++; if (s !== 32'h2) begin failures++; $display("FAIL rst_mid_status: got %h expected 2", s); end
        stayed_high = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        checks++; if (!stayed_high || got_q.size() != 0) begin failures++; $display("FAIL rst_mid_no_frame: high %b frames %0d expected 1 0", stayed_high, got_q.size()); end
    endtask

    task automatic test_reads;
        bit ok;
        frame_t f;
        logic [7:0] e;
        do_write(32'h0, 32'hC3);
        exp_q.push_back(8'hC3);
        re = 1'b1; address = 32'h0; #1;
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL read_txdata: got %h expected 0", rd); end
        re = 1'b0; address = 32'h4; #1;
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL read_no_re: got %h expected 0", rd); end
        re = 1'b1; address = 32'hC; #1;
        checks++; if (rd !== 32'h14) begin failures++; $display("FAIL read_alias_status: got %h expected 14", rd); end
        re = 1'b0; address = '0;
        wait_frames(1, FRAME + 20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL read_frame_timeout: got %0d frames expected 1", got_q.size());
        end else begin
            f = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (f.data !== e) begin failures++; $display("FAIL read_frame_data: got %h expected %h", f.data, e); end
        end
        wait_idle(FRAME, ok);
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_reads;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
